multu_seq: RTL and testbench

Iterative radix-2 shift-add multiplier for the execute stage, upstream of the HiLo register pair. On an accepted MULTU request it computes the 64-bit unsigned product of two 32-bit operands over 32 iteration cycles and presents it for HiLo to capture. It raises a stall to the pipeline while busy, and pulses done for exactly one cycle when the product is valid.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/mul_add_shift.sv | 22 ++
 rtl/multu_seq.sv | 113 +++++++++++
 tb/tb_multu_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared execute-stage definitions: funct codes, multiplier FSM states and the
// default datapath width used by the sequential multiplier.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_add_shift.sv
// One radix-2 shift-add step: conditionally add the multiplicand into the
// carry-extended accumulator, then shift {acc, lo} right by one.
module mul_add_shift #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;

  // acc stays below 2**WIDTH after every shift, so the 33-bit sum never overflows.
  always_comb begin
    sum      = acc + ({1'b0, mcand} & {(WIDTH+1){lo[0]}});
    acc_next = {1'b0, sum[WIDTH:1]};
    lo_next  = {sum[0], lo[WIDTH-1:1]};
  end

endmodule

// File: rtl/multu_seq.sv
// Iterative 32-cycle shift-add multiplier feeding HiLo; stalls the pipeline while busy.
// Optional signed MULT support is enabled by defining SIGNED_MULT_EN.
import alu_pkg::*;

module multu_seq #(
  parameter int         WIDTH       = DEFAULT_WIDTH,
  parameter logic [5:0] MULTU_FUNCT = FUNCT_MULTU
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [5:0]         Signal,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               stall,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_t       state;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand_r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]     acc_next;
  logic [WIDTH-1:0]   lo_next;
  logic [2*WIDTH-1:0] result;
  logic               is_mul;
  logic               accept;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;

`ifdef SIGNED_MULT_EN
  logic is_signed;
  logic neg_r;

  // Signed requests iterate on magnitudes; the sign is reapplied when the result lands.
  assign is_signed = (Signal == FUNCT_MULT);
  assign is_mul    = (Signal == MULTU_FUNCT) | is_signed;
  assign op_a      = (is_signed & multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
  assign op_b      = (is_signed & multiplier[WIDTH-1])   ? -multiplier   : multiplier;
  assign result    = neg_r ? -{acc_next[WIDTH-1:0], lo_next} : {acc_next[WIDTH-1:0], lo_next};
`else
  assign is_mul    = (Signal == MULTU_FUNCT);
  assign op_a      = multiplicand;
  assign op_b      = multiplier;
  assign result    = {acc_next[WIDTH-1:0], lo_next};
`endif

  assign accept = start & is_mul & (state != RUN);
  assign stall  = busy | accept;

  mul_add_shift #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .lo       (lo),
    .mcand    (mcand_r),
    .acc_next (acc_next),
    .lo_next  (lo_next)
  );

  // Requests seen while RUN are dropped; IDLE and DONE both accept a new operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      lo      <= '0;
      mcand_r <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SIGNED_MULT_EN
      neg_r   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          acc <= acc_next;
          lo  <= lo_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= result;
          end
        end
        default: begin
          if (accept) begin
            state   <= RUN;
            busy    <= 1'b1;
            acc     <= '0;
            lo      <= op_b;
            mcand_r <= op_a;
            cnt     <= '0;
`ifdef SIGNED_MULT_EN
            neg_r   <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
`endif
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multu_seq.sv
// Self-checking bench for multu_seq: directed scenarios plus random operands
// compared against plain 64-bit arithmetic.
module tb_multu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  Signal;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        stall;
  logic        done;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  multu_seq dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .Signal       (Signal),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .stall        (stall),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  // Present a request for one cycle; the following posedge is edge 0.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    @(negedge clk);
    start = 1'b1; Signal = f; multiplicand = a; multiplier = b;
    @(posedge clk);
    #1;
    start = 1'b0; Signal = FUNCT_ADD;
  endtask

  // Count cycles after edge 0 until done; -1 means no done within the budget.
  task automatic wait_done(output int lat, output int busy_n, output int stall_n);
    lat = -1; busy_n = 0; stall_n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (stall) stall_n++;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; Signal = FUNCT_ADD; multiplicand = '0; multiplier = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b want 0", stall); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (product !== 64'd0) begin errors++; $display("[TB] FAIL reset_product got %h want 0", product); end
  endtask

  task automatic test_basic();
    int lat, bn, sn;
    issue(32'd3, 32'd5, FUNCT_MULTU);
    wait_done(lat, bn, sn);
    checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL basic_latency got %0d want 33", lat); end
    checks++; if (bn !== 32) begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d want 32", bn); end
    checks++; if (product !== 64'h0000_0000_0000_000F) begin errors++; $display("[TB] FAIL basic_product got %h want f", product); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse got %b want 0", done); end
    checks++; if (product !== 64'h0000_0000_0000_000F) begin errors++; $display("[TB] FAIL basic_hold got %h want f", product); end
  endtask

  task automatic test_max();
    int lat, bn, sn;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, FUNCT_MULTU);
    wait_done(lat, bn, sn);
    checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL max_latency got %0d want 33", lat); end
    checks++; if (product !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("[TB] FAIL max_product got %h want fffffffe00000001", product); end
  endtask

  task automatic test_ignore();
    int lat, bn, sn;
    logic [63:0] prev;
    prev = product;
    @(negedge clk);
    start = 1'b1; Signal = FUNCT_ADD; multiplicand = 32'd9; multiplier = 32'd9;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL ignore_funct_stall got %b want 0", stall); end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_funct_busy got %b want 0", busy); end
    checks++; if (product !== prev) begin errors++; $display("[TB] FAIL ignore_funct_product got %h want %h", product, prev); end
    // Keep requesting with fresh operands for the whole run; none may be sampled.
    issue(32'h0000_1234, 32'h0000_0100, FUNCT_MULTU);
    start = 1'b1; Signal = FUNCT_MULTU; multiplicand = 32'hDEAD_BEEF; multiplier = 32'h0BAD_F00D;
    wait_done(lat, bn, sn);
    start = 1'b0; Signal = FUNCT_ADD;
    checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL ignore_run_latency got %0d want 33", lat); end
    checks++; if (product !== 64'h0000_0000_0012_3400) begin errors++; $display("[TB] FAIL ignore_run_product got %h want 123400", product); end
  endtask

  task automatic test_back_to_back();
    int lat, bn, sn;
    issue(32'h0001_0000, 32'h0001_0000, FUNCT_MULTU);
    wait_done(lat, bn, sn);
    checks++; if (product !== 64'h0000_0001_0000_0000) begin errors++; $display("[TB] FAIL b2b_first got %h want 100000000", product); end
    start = 1'b1; Signal = FUNCT_MULTU; multiplicand = 32'd7; multiplier = 32'd6;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done_stall got %b want 1", stall); end
    @(posedge clk);
    #1 start = 1'b0; Signal = FUNCT_ADD;
    wait_done(lat, bn, sn);
    checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL b2b_interval got %0d want 33", lat); end
    checks++; if (sn !== 32) begin errors++; $display("[TB] FAIL b2b_stall_cycles got %0d want 32", sn); end
    checks++; if (product !== 64'd42) begin errors++; $display("[TB] FAIL b2b_second got %h want 2a", product); end
  endtask

  task automatic test_random();
    int lat, bn, sn;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 12; i++) begin
      a = (i == 0) ? 32'd0 : $urandom;
      b = (i == 1) ? 32'd0 : $urandom;
      exp = 64'(a) * 64'(b);
      issue(a, b, FUNCT_MULTU);
      wait_done(lat, bn, sn);
      checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL rand_latency[%0d] got %0d want 33", i, lat); end
      checks++; if (product !== exp) begin errors++; $display("[TB] FAIL rand_product[%0d] got %h want %h", i, product, exp); end
    end
  endtask

  task automatic test_signed();
    int lat, bn, sn;
    logic [63:0] prev;
    prev = product;
    issue(32'hFFFF_FFFE, 32'h0000_0003, FUNCT_MULT);
    wait_done(lat, bn, sn);
`ifdef SIGNED_MULT_EN
    checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL signed_latency got %0d want 33", lat); end
    checks++; if (product !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("[TB] FAIL signed_product got %h want fffffffffffffffa", product); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      logic [63:0] exp;
      a = $urandom; b = $urandom;
      exp = 64'($signed(a)) * 64'($signed(b));
      issue(a, b, FUNCT_MULT);
      wait_done(lat, bn, sn);
      checks++; if (product !== exp) begin errors++; $display("[TB] FAIL signed_rand[%0d] got %h want %h", i, product, exp); end
    end
`else
    checks++; if (lat !== -1) begin errors++; $display("[TB] FAIL mult_ignored_done got %0d want -1", lat); end
    checks++; if (bn !== 0) begin errors++; $display("[TB] FAIL mult_ignored_busy got %0d want 0", bn); end
    checks++; if (product !== prev) begin errors++; $display("[TB] FAIL mult_ignored_product got %h want %h", product, prev); end
`endif
  endtask

  task automatic test_reset_mid();
    int lat, bn, sn;
    issue(32'h1234_5678, 32'h9ABC_DEF0, FUNCT_MULTU);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b want 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL midreset_stall got %b want 0", stall); end
    checks++; if (product !== 64'd0) begin errors++; $display("[TB] FAIL midreset_product got %h want 0", product); end
    wait_done(lat, bn, sn);
    checks++; if (lat !== -1) begin errors++; $display("[TB] FAIL midreset_no_done got %0d want -1", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_ignore();
    test_back_to_back();
    test_random();
    test_signed();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
